// File: rtl/apb_timer_slave.sv
// apb_timer_slave
//   APB3 completer exposing a prescaled 32-bit up-counter with compare match
//   and a level interrupt. Every access takes WAIT_STATES wait cycles, and
//   illegal accesses return PSLVERR.
//
//   Parameters
//     WAIT_STATES  access-phase cycles with PREADY low (0..15)
//     PRESC_W      prescaler width (1..32)
//
//   Ports
//     PCLK, PRESETn        clock (rising edge), async active-low reset
//     PSEL, PENABLE        APB select / access phase
//     PWRITE, PADDR        direction, byte address (PADDR[1:0] must be 0)
//     PWDATA, PSTRB        write data and byte strobes
//     PRDATA               read data, non-zero only in the completion cycle
//     PREADY, PSLVERR      completion and error response
//     IRQ_O                MATCH & IRQ_EN
//
//   Register map
//     0x0 CTRL  [0]EN [1]AUTO_RELOAD [2]IRQ_EN [3]CLR (reads 0) [8]MATCH (W1C)
//     0x4 PRESC tick every PRESC+1 cycles
//     0x8 CMP
//     0xC COUNT read-only
module apb_timer_slave #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned PRESC_W     = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        IRQ_O
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    // Wait-counter value on which ACCESS hands over to DONE.
    localparam logic [3:0] WaitLast = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [PRESC_W-1:0] PrescOne = PRESC_W'(1);

    state_e              state_q, state_d;
    logic [3:0]          wait_q, wait_d;
    logic                en_q, en_d;
    logic                auto_q, auto_d;
    logic                irq_en_q, irq_en_d;
    logic                match_q, match_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
    logic [31:0]         cmp_q, cmp_d;
    logic [31:0]         count_q, count_d;

    logic        done;
    logic        err;
    logic        wr_ok;
    logic        wr_ctrl;
    logic        wr_presc;
    logic        wr_cmp;
    logic [31:0] wmask;
    logic [31:0] rdata;
    logic        tick;
    logic        match_set;
    logic        match_clr;

    // ---------------------------------------------------------------------
    // Transfer FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (PSEL && !PENABLE) begin
                    wait_d  = 4'd0;
                    state_d = (WAIT_STATES == 0) ? StDone : StAccess;
                end
            end
            StAccess: begin
                if (!PSEL) begin
                    // Aborted transfer: no write, no PREADY.
                    state_d = StIdle;
                end else if (wait_q == WaitLast) begin
                    state_d = StDone;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------------
    // Access decode and read mux
    // ---------------------------------------------------------------------
    assign done     = (state_q == StDone);
    assign err      = (PADDR[1:0] != 2'b00) ||
                      (PWRITE && ((PADDR[3:2] == 2'd3) || (PSTRB == 4'b0000)));
    assign wr_ok    = done && PWRITE && !err;
    assign wr_ctrl  = wr_ok && (PADDR[3:2] == 2'd0);
    assign wr_presc = wr_ok && (PADDR[3:2] == 2'd1);
    assign wr_cmp   = wr_ok && (PADDR[3:2] == 2'd2);
    assign wmask    = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};

    always_comb begin
        rdata = 32'd0;
        case (PADDR[3:2])
            2'd0:    rdata = {23'd0, match_q, 5'd0, irq_en_q, auto_q, en_q};
            2'd1:    rdata = 32'(presc_q);
            2'd2:    rdata = cmp_q;
            default: rdata = count_q;
        endcase
    end

    assign PRDATA  = (done && !PWRITE && !err) ? rdata : 32'd0;
    assign PREADY  = done;
    assign PSLVERR = done && err;
    assign IRQ_O   = match_q & irq_en_q;

    // ---------------------------------------------------------------------
    // Timer and register next-state
    // ---------------------------------------------------------------------
    assign tick      = en_q && (pcnt_q == presc_q);
    assign match_clr = wr_ctrl && PSTRB[1] && PWDATA[8];

    always_comb begin
        en_d      = en_q;
        auto_d    = auto_q;
        irq_en_d  = irq_en_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        cmp_d     = cmp_q;
        count_d   = count_q;
        match_set = 1'b0;

        if (en_q) begin
            pcnt_d = tick ? '0 : pcnt_q + PrescOne;
        end

        if (tick) begin
            if (count_q == cmp_q) begin
                match_set = 1'b1;
                if (auto_q) begin
                    count_d = 32'd0;
                end else begin
                    en_d = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        // Software writes come after the timer update so they take priority
        // (EN over one-shot stop, CLR over a same-cycle tick).
        if (wr_ctrl && PSTRB[0]) begin
            if (PWDATA[0] && !en_q) begin
                pcnt_d = '0;
            end
            en_d     = PWDATA[0];
            auto_d   = PWDATA[1];
            irq_en_d = PWDATA[2];
            if (PWDATA[3]) begin
                count_d = 32'd0;
                pcnt_d  = '0;
            end
        end

        if (wr_presc) begin
            presc_d = (presc_q & ~wmask[PRESC_W-1:0]) | (PWDATA[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
            pcnt_d  = '0;
        end

        if (wr_cmp) begin
            cmp_d = (cmp_q & ~wmask) | (PWDATA & wmask);
        end
    end

    // Hardware set beats a same-cycle W1C clear.
    assign match_d = (match_q & ~match_clr) | match_set;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= StIdle;
            wait_q   <= 4'd0;
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            irq_en_q <= 1'b0;
            match_q  <= 1'b0;
            presc_q  <= '0;
            pcnt_q   <= '0;
            cmp_q    <= 32'd0;
            count_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            irq_en_q <= irq_en_d;
            match_q  <= match_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            cmp_q    <= cmp_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave (WAIT_STATES=1, PRESC_W=16).
module tb_apb_timer_slave;

    localparam int unsigned WS = 1;
    localparam int unsigned PW = 16;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        IRQ_O;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    apb_timer_slave #(
        .WAIT_STATES (WS),
        .PRESC_W     (PW)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .IRQ_O   (IRQ_O)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // One APB transfer, started and ended on a falling edge. scyc is the
    // cycle count at the sample point of the completion cycle.
    task automatic apb(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                       output int lat, output int unsigned scyc);
        rdata   = 32'd0;
        err     = 1'b0;
        scyc    = 0;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        PSTRB   = strb;
        @(negedge PCLK);
        PENABLE = 1'b1;
        lat     = 1;
        while (!PREADY && lat < 20) begin
            @(negedge PCLK);
            lat++;
        end
        if (!PREADY) begin
            n_tests++;
            n_fail++;
            $display("FAIL apb_timeout: got no PREADY after %0d cycles required PREADY", lat);
        end
        rdata = PRDATA;
        err   = PSLVERR;
        scyc  = cyc;
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    // Timer state m cycles after an enable+clear write, from tick arithmetic.
    function automatic void tmodel(input int unsigned m, input int unsigned p, input int unsigned c,
                                   input bit au, output logic [31:0] cnt, output bit en,
                                   output bit mat);
        int unsigned t;
        t   = m / (p + 1);
        mat = (t > c);
        if (au) begin
            cnt = t % (c + 1);
            en  = 1'b1;
        end else begin
            cnt = (t < c) ? t : c;
            en  = (t <= c);
        end
    endfunction

    function automatic logic [31:0] ctrl_word(input bit mat, input bit ie, input bit au,
                                              input bit en);
        return {23'd0, mat, 5'd0, ie, au, en};
    endfunction

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic [31:0] rd, exp, d, ecnt;
        logic        er, w, exp_err;
        logic [3:0]  a, s;
        int          lat, n;
        int unsigned sc, e0, p, c;
        bit          au, ie, een, emat;
        logic [31:0] m_cmp, m_presc;
        bit          m_au, m_ie;

        vecs[0]  = '{1'b1, 4'h8, 32'h0000_0005, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'h8, 32'h0,         4'h0, 1'b0, 32'h0000_0005};
        vecs[2]  = '{1'b1, 4'hC, 32'h0000_1234, 4'hF, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 4'hC, 32'h0,         4'h0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 4'h6, 32'h0,         4'h0, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 4'h8, 32'h0000_0077, 4'h0, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 4'h8, 32'h0,         4'h0, 1'b0, 32'h0000_0005};
        vecs[7]  = '{1'b1, 4'h8, 32'h0,         4'hF, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 4'h8, 32'hAABB_CCDD, 4'h2, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 4'h8, 32'h0,         4'h0, 1'b0, 32'h0000_CC00};
        vecs[10] = '{1'b1, 4'h4, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 4'h4, 32'h0,         4'h0, 1'b0, 32'h0000_5678};
        vecs[12] = '{1'b1, 4'h4, 32'h0000_FF00, 4'h1, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 4'h4, 32'h0,         4'h0, 1'b0, 32'h0000_5600};
        vecs[14] = '{1'b1, 4'h0, 32'h0000_0006, 4'h1, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 4'h0, 32'h0,         4'h0, 1'b0, 32'h0000_0006};
        vecs[16] = '{1'b1, 4'h0, 32'h0000_0008, 4'h1, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 4'h0, 32'h0,         4'h0, 1'b0, 32'h0};
        vecs[18] = '{1'b1, 4'h1, 32'h0000_0007, 4'hF, 1'b1, 32'h0};
        vecs[19] = '{1'b0, 4'h0, 32'h0,         4'h0, 1'b0, 32'h0};

        // Reset state
        PRESETn = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 4'h0;
        PWDATA  = 32'd0;
        PSTRB   = 4'h0;
        repeat (3) @(negedge PCLK);
        check("reset_pready", {31'd0, PREADY}, 32'd0);
        check("reset_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("reset_prdata", PRDATA, 32'd0);
        check("reset_irq", {31'd0, IRQ_O}, 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Directed register vectors
        for (int i = 0; i < 20; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, rd, er, lat, sc);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(WS + 1));
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // Randomised register accesses against a register-map model (EN kept 0)
        m_cmp   = 32'h0000_CC00;
        m_presc = 32'h0000_5600;
        m_au    = 1'b0;
        m_ie    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (a[3:2] == 2'd0) d[0] = 1'b0;
            exp_err = (a[1:0] != 2'b00) || (w && ((a[3:2] == 2'd3) || (s == 4'h0)));
            apb(w, a, d, s, rd, er, lat, sc);
            check("rand_err", {31'd0, er}, {31'd0, exp_err});
            check("rand_latency", 32'(lat), 32'(WS + 1));
            if (!w) begin
                if (a[3:2] == 2'd0)      exp = ctrl_word(1'b0, m_ie, m_au, 1'b0);
                else if (a[3:2] == 2'd1) exp = m_presc & 32'h0000_FFFF;
                else if (a[3:2] == 2'd2) exp = m_cmp;
                else                     exp = 32'd0;
                if (exp_err) exp = 32'd0;
                check("rand_rdata", rd, exp);
            end else if (!exp_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) begin
                        if (a[3:2] == 2'd1) m_presc[8*b +: 8] = d[8*b +: 8];
                        if (a[3:2] == 2'd2) m_cmp[8*b +: 8] = d[8*b +: 8];
                    end
                end
                if (a[3:2] == 2'd0 && s[0]) begin
                    m_au = d[1];
                    m_ie = d[2];
                end
            end
        end

        // Abort: PSEL dropped during the wait state
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 4'h8;
        PWDATA  = 32'hDEAD_BEEF;
        PSTRB   = 4'hF;
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("abort_no_pready", {31'd0, PREADY}, 32'd0);
        end
        apb(1'b0, 4'h8, 32'd0, 4'h0, rd, er, lat, sc);
        check("abort_cmp_unchanged", rd, m_cmp);

        // Auto-reload: PRESC=1, CMP=3, CTRL=0x7
        apb(1'b1, 4'h4, 32'd1, 4'hF, rd, er, lat, sc);
        apb(1'b1, 4'h8, 32'd3, 4'hF, rd, er, lat, sc);
        apb(1'b1, 4'h0, 32'h7, 4'hF, rd, er, lat, sc);
        e0 = cyc;
        n  = 0;
        while (!IRQ_O && n < 40) begin
            @(negedge PCLK);
            n++;
        end
        check("auto_irq_delay", 32'(n), 32'd8);
        apb(1'b0, 4'hC, 32'd0, 4'h0, rd, er, lat, sc);
        tmodel(sc - e0, 1, 3, 1'b1, ecnt, een, emat);
        check("auto_count", rd, ecnt);
        apb(1'b0, 4'h0, 32'd0, 4'h0, rd, er, lat, sc);
        tmodel(sc - e0, 1, 3, 1'b1, ecnt, een, emat);
        check("auto_ctrl", rd, ctrl_word(emat, 1'b1, 1'b1, een));
        apb(1'b1, 4'h0, 32'h100, 4'hF, rd, er, lat, sc);
        check("auto_irq_cleared", {31'd0, IRQ_O}, 32'd0);

        // One-shot: CMP=2, IRQ_EN, stops at CMP with EN cleared
        apb(1'b1, 4'h4, 32'd0, 4'hF, rd, er, lat, sc);
        apb(1'b1, 4'h8, 32'd2, 4'hF, rd, er, lat, sc);
        apb(1'b1, 4'h0, 32'h10D, 4'hF, rd, er, lat, sc);
        repeat (10) @(negedge PCLK);
        apb(1'b0, 4'hC, 32'd0, 4'h0, rd, er, lat, sc);
        check("oneshot_count", rd, 32'd2);
        apb(1'b0, 4'h0, 32'd0, 4'h0, rd, er, lat, sc);
        check("oneshot_ctrl", rd, 32'h0000_0104);
        check("oneshot_irq", {31'd0, IRQ_O}, 32'd1);
        apb(1'b1, 4'h0, 32'h100, 4'hF, rd, er, lat, sc);
        check("oneshot_irq_w1c", {31'd0, IRQ_O}, 32'd0);
        apb(1'b0, 4'h0, 32'd0, 4'h0, rd, er, lat, sc);
        check("oneshot_ctrl_w1c", rd, 32'd0);

        // Randomised timer runs against the tick-arithmetic model
        for (int i = 0; i < 8; i++) begin
            p  = $urandom_range(0, 3);
            c  = $urandom_range(0, 6);
            au = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            n  = int'($urandom_range(0, 30));
            apb(1'b1, 4'h4, p, 4'hF, rd, er, lat, sc);
            apb(1'b1, 4'h8, c, 4'hF, rd, er, lat, sc);
            apb(1'b1, 4'h0, 32'h109 | {29'd0, ie, au, 1'b0}, 4'h3, rd, er, lat, sc);
            e0 = cyc;
            repeat (n) @(negedge PCLK);
            apb(1'b0, 4'hC, 32'd0, 4'h0, rd, er, lat, sc);
            tmodel(sc - e0, p, c, au, ecnt, een, emat);
            check("rtimer_count", rd, ecnt);
            apb(1'b0, 4'h0, 32'd0, 4'h0, rd, er, lat, sc);
            tmodel(sc - e0, p, c, au, ecnt, een, emat);
            check("rtimer_ctrl", rd, ctrl_word(emat, ie, au, een));
            tmodel(cyc - e0, p, c, au, ecnt, een, emat);
            check("rtimer_irq", {31'd0, IRQ_O}, {31'd0, emat & ie});
            apb(1'b1, 4'h0, 32'h108, 4'h3, rd, er, lat, sc);
        end

        // Asynchronous reset during ACCESS with the timer running
        apb(1'b1, 4'h4, 32'd0, 4'hF, rd, er, lat, sc);
        apb(1'b1, 4'h8, 32'd5, 4'hF, rd, er, lat, sc);
        apb(1'b1, 4'h0, 32'h10F, 4'h3, rd, er, lat, sc);
        e0 = cyc;
        repeat (6) @(negedge PCLK);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 4'hC;
        PSTRB   = 4'h0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        tmodel(cyc - e0, 0, 5, 1'b1, ecnt, een, emat);
        check("rst_irq_before", {31'd0, IRQ_O}, {31'd0, emat});
        #2;
        PRESETn = 1'b0;
        #1;
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst_irq", {31'd0, IRQ_O}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        apb(1'b0, 4'hC, 32'd0, 4'h0, rd, er, lat, sc);
        check("rst_count", rd, 32'd0);
        check("rst_latency", 32'(lat), 32'(WS + 1));
        apb(1'b0, 4'h0, 32'd0, 4'h0, rd, er, lat, sc);
        check("rst_ctrl", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
